// File: rtl/dtc_window_vote.sv
`default_nettype none
// ============================================================================
// Module   : dtc_window_vote
// Brief    : Windowed majority vote over 3-bit classifier codes with a
//            registered valid/ready result (winning code, count, tie flag).
// Revision : 1.0
// ============================================================================
module dtc_window_vote #(
    parameter  int WIN_LEN = 16,
    localparam int CNT_W   = $clog2(WIN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_class,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_class,
    output logic [CNT_W-1:0] out_count,
    output logic             out_tie
);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_REDUCE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] n_q;
    logic [2:0]       idx_q;
    logic [2:0]       best_cls_q, best_cls_d;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
    logic             tie_q, tie_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [2:0]       out_class_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_tie_q;

    logic [CNT_W-1:0] w_cur_cnt;
    logic             w_accept;
    logic             w_last;

    assign w_cur_cnt = cnt_q[idx_q];
    assign w_accept  = (state_q == ST_ACCUM) && in_valid && in_ready_q;
    assign w_last    = (n_q == CNT_W'(WIN_LEN - 1));

    // Strict greater-than keeps the lowest code on equal counts; empty codes never tie.
    always_comb begin
        best_cls_d = best_cls_q;
        best_cnt_d = best_cnt_q;
        tie_d      = tie_q;
        if (w_cur_cnt > best_cnt_q) begin
            best_cls_d = idx_q;
            best_cnt_d = w_cur_cnt;
            tie_d      = 1'b0;
        end else if ((w_cur_cnt == best_cnt_q) && (best_cnt_q != '0)) begin
            tie_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            best_cls_q  <= '0;
            best_cnt_q  <= '0;
            tie_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_count_q <= '0;
            out_tie_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    in_ready_q <= 1'b1;
                    if (w_accept) begin
                        cnt_q[in_class] <= cnt_q[in_class] + CNT_W'(1);
                        n_q             <= n_q + CNT_W'(1);
                        if (w_last) begin
                            state_q    <= ST_REDUCE;
                            in_ready_q <= 1'b0;
                            idx_q      <= '0;
                            best_cls_q <= '0;
                            best_cnt_q <= '0;
                            tie_q      <= 1'b0;
                        end
                    end
                end
                ST_REDUCE: begin
                    best_cls_q <= best_cls_d;
                    best_cnt_q <= best_cnt_d;
                    tie_q      <= tie_d;
                    idx_q      <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                        out_class_q <= best_cls_d;
                        out_count_q <= best_cnt_d;
                        out_tie_q   <= tie_d;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_q     <= ST_ACCUM;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
                        n_q         <= '0;
                    end
                end
                default: state_q <= ST_ACCUM;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_count = out_count_q;
    assign out_tie   = out_tie_q;

endmodule
`default_nettype wire
